instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Top-level instruction-cycle controller that sequences the microcode unit.
- Fetches a 32-bit MIPS instruction from instruction memory.
- Maps opcode/funct to a microcode segment index and fires a one-cycle sos pulse.
- Waits for eos, then updates the PC (sequential, BEQ, or J).
- Sits between imem, the microcode unit (drives its opcode/sos inputs, reads its eos) and the datapath (drives ir, reads br_taken).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_UOPS, 16, maximum EXEC cycles per segment before a timeout fault
SEG_W, 6, width of the segment index driven to the microcode opcode input

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
seg_idx  out  SEG_W  segment index to the microcode unit
sos  out  1  start-of-segment pulse to the microcode unit
eos  in  1  end-of-segment from the microcode unit
br_taken  in  1  ALU zero/compare result for BEQ, sampled with eos
ir  out  32  latched current instruction for the datapath
pc  out  32  current program counter
busy  out  1  high in every state except HALT and FAULT
halted  out  1  sticky; halt opcode executed
illegal  out  1  sticky; unmapped opcode/funct decoded
timeout  out  1  sticky; eos not seen within MAX_UOPS cycles

Behaviour:
- Reset (sync, active-high, wins over all other inputs, including mid-fetch or mid-segment):
  - pc=RESET_PC, ir=0, imem_req=0, sos=0, seg_idx=6'h3F (freezes microcode).
  - halted=illegal=timeout=0, uop counter=0, state=FETCH.
- States: FETCH, WAIT_MEM, DECODE, LAUNCH, EXEC, UPDATE, HALT, FAULT.
- FETCH: assert imem_req with imem_addr=pc; go to WAIT_MEM.
- WAIT_MEM: imem_req stays high and imem_addr stable until imem_ack. On ack, ir<=imem_rdata, imem_req<=0, go to DECODE. imem_ack while imem_req is low is ignored.
- DECODE: map ir[31:26] (and ir[5:0] when opcode=0) using the package table. Register seg_idx.
  - Valid entry -> LAUNCH.
  - opcode 6'h3F -> seg_idx=6'h3F, halted<=1, go to HALT.
  - Unmapped -> seg_idx=6'h3F, illegal<=1, go to FAULT.
- LAUNCH: sos=1 for exactly one cycle; seg_idx is already stable from the previous cycle. Clear the uop counter; go to EXEC.
- EXEC: sos=0; seg_idx held. eos is sampled only here and is ignored in every other state, because eos is stale before sos.
  - eos=1 -> latch br_taken, go to UPDATE. A one-microinstruction segment completes on the first EXEC cycle.
  - eos=0 -> counter+1. When the counter reaches MAX_UOPS-1 with eos still 0 -> timeout<=1, go to FAULT.
- UPDATE: pc4=pc+4 (mod 2^32).
  - BEQ with latched br_taken=1: pc<=pc4+({{14{ir[15]}},ir[15:0],2'b00}).
  - J: pc<={pc4[31:28],ir[25:0],2'b00}.
  - Otherwise pc<=pc4.
  - Go to FETCH. Total for a 1-uop instruction with 1-cycle ack: FETCH, WAIT_MEM, DECODE, LAUNCH, EXEC, UPDATE = 6 cycles.
- HALT / FAULT: terminal. sos=0, imem_req=0, busy=0, pc and ir frozen. Only rst exits.
- PC wrap: 32'hFFFF_FFFC+4 = 0, no flag.

Decomposition:
- Package seq_pkg:
  - state enum.
  - opcode constants: OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_LW=6'h23, OP_SW=6'h2B, OP_HALT=6'h3F.
  - funct constants: ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, SLT=6'h2A.
  - Segment index constants, matching microcode programming order: LW=0, SW=1, ADD=2, SUB=3, AND=4, OR=5, SLT=6, BEQ=7, J=8. SEG_INVALID=6'h3F.
- One combinational sub-module, seq_decode: ir in -> {valid, is_halt, is_beq, is_j, seg_idx} out.

Test Plan:
- LW at pc=0 (ir=32'h8C01_0004), ack after 1 cycle, eos on 4th EXEC cycle -> seg_idx=0, single sos pulse, pc=4, busy high throughout.
- SW (ir=32'hAC01_0000), eos=1 on first EXEC cycle -> seg_idx=1, UPDATE next cycle, pc=4; stale eos=1 held during FETCH/DECODE causes no early completion.
- BEQ at pc=8, imm=16'hFFFE, br_taken=1 with eos -> pc=8+4-8=4. Same instruction with br_taken=0 -> pc=12.
- J at pc=32'h1000_0000, ir=32'h0800_0010 -> pc=32'h1000_0040. ADD (funct 0x20) -> seg_idx=2.
- ir=32'hFC00_0000 -> halted=1, seg_idx=6'h3F, busy=0, no further imem_req. Unmapped ir=32'h0000_003F -> illegal=1, FAULT.
- eos held 0 for MAX_UOPS cycles -> timeout=1, FAULT. rst asserted mid-WAIT_MEM and mid-EXEC -> next cycle pc=RESET_PC, sos=0, imem_req=0, flags clear, state FETCH.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and encoding tables for the instruction sequencer.
package seq_pkg;

   // Controller states, in instruction-cycle order.
   typedef enum logic [2:0] {
      S_FETCH,
      S_WAIT_MEM,
      S_DECODE,
      S_LAUNCH,
      S_EXEC,
      S_UPDATE,
      S_HALT,
      S_FAULT
   } state_t;

   // Primary opcodes (ir[31:26]).
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // R-type function codes (ir[5:0]).
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // Microcode segment indices, in the order the microcode ROM is programmed.
   localparam logic [5:0] SEG_LW      = 6'd0;
   localparam logic [5:0] SEG_SW      = 6'd1;
   localparam logic [5:0] SEG_ADD     = 6'd2;
   localparam logic [5:0] SEG_SUB     = 6'd3;
   localparam logic [5:0] SEG_AND     = 6'd4;
   localparam logic [5:0] SEG_OR      = 6'd5;
   localparam logic [5:0] SEG_SLT     = 6'd6;
   localparam logic [5:0] SEG_BEQ     = 6'd7;
   localparam logic [5:0] SEG_J       = 6'd8;
   localparam logic [5:0] SEG_INVALID = 6'h3F;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode/funct to microcode-segment decoder.
module seq_decode
   import seq_pkg::*;
#(
   parameter int SEG_W = 6
) (
   input  logic [31:0]      i_ir,
   output logic             o_valid,
   output logic             o_is_halt,
   output logic             o_is_beq,
   output logic             o_is_j,
   output logic [SEG_W-1:0] o_seg_idx
);

   logic [5:0] w_op;
   logic [5:0] w_fn;

   assign w_op = i_ir[31:26];
   assign w_fn = i_ir[5:0];

   // Table lookup; anything not listed stays invalid with the freeze index.
   // NOTE: every output gets a default first so no path through the case can infer a latch.
   always_comb begin
      o_valid   = 1'b0;
      o_is_halt = 1'b0;
      o_is_beq  = 1'b0;
      o_is_j    = 1'b0;
      o_seg_idx = SEG_W'(SEG_INVALID);
      case (w_op)
         OP_RTYPE: begin
            case (w_fn)
               FN_ADD:  begin o_valid = 1'b1; o_seg_idx = SEG_W'(SEG_ADD); end
               FN_SUB:  begin o_valid = 1'b1; o_seg_idx = SEG_W'(SEG_SUB); end
               FN_AND:  begin o_valid = 1'b1; o_seg_idx = SEG_W'(SEG_AND); end
               FN_OR:   begin o_valid = 1'b1; o_seg_idx = SEG_W'(SEG_OR);  end
               FN_SLT:  begin o_valid = 1'b1; o_seg_idx = SEG_W'(SEG_SLT); end
               default: ;
            endcase
         end
         OP_LW:   begin o_valid = 1'b1; o_seg_idx = SEG_W'(SEG_LW); end
         OP_SW:   begin o_valid = 1'b1; o_seg_idx = SEG_W'(SEG_SW); end
         OP_BEQ:  begin o_valid = 1'b1; o_is_beq = 1'b1; o_seg_idx = SEG_W'(SEG_BEQ); end
         OP_J:    begin o_valid = 1'b1; o_is_j   = 1'b1; o_seg_idx = SEG_W'(SEG_J);   end
         OP_HALT: o_is_halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-cycle controller: fetch, decode, launch a microcode segment,
// wait for its end, then advance the PC.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MAX_UOPS = 16,
   parameter int          SEG_W    = 6
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [SEG_W-1:0] seg_idx,
   output logic             sos,
   input  logic             eos,
   input  logic             br_taken,
   output logic [31:0]      ir,
   output logic [31:0]      pc,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic             timeout
);

   localparam int CNT_W = (MAX_UOPS > 2) ? $clog2(MAX_UOPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_UOPS - 1);

   state_t             r_state;
   state_t             w_next;
   logic [31:0]        r_pc;
   logic [31:0]        r_ir;
   logic               r_imem_req;
   logic [SEG_W-1:0]   r_seg_idx;
   logic               r_halted;
   logic               r_illegal;
   logic               r_timeout;
   logic               r_br;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_dec_valid;
   logic               w_dec_halt;
   logic               w_dec_beq;
   logic               w_dec_j;
   logic [SEG_W-1:0]   w_dec_seg;
   logic               w_ack;
   logic               w_cnt_last;
   logic [31:0]        w_pc4;
   logic [31:0]        w_br_off;
   logic [31:0]        w_pc_next;
   logic               w_sos;
   logic               w_busy;

   seq_decode #(.SEG_W(SEG_W)) u_decode (
      .i_ir      (r_ir),
      .o_valid   (w_dec_valid),
      .o_is_halt (w_dec_halt),
      .o_is_beq  (w_dec_beq),
      .o_is_j    (w_dec_j),
      .o_seg_idx (w_dec_seg)
   );

   // An ack only counts while a request is outstanding.
   assign w_ack      = imem_ack && r_imem_req;
   assign w_cnt_last = (r_cnt == CNT_LAST);

   assign w_pc4    = r_pc + 32'd4;
   assign w_br_off = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

   // Next PC: taken branch, jump, or fall through (all wrap mod 2^32).
   always_comb begin
      w_pc_next = w_pc4;
      if (w_dec_beq && r_br)
         w_pc_next = w_pc4 + w_br_off;
      else if (w_dec_j)
         w_pc_next = {w_pc4[31:28], r_ir[25:0], 2'b00};
   end

   // State register; reset wins over every other input.
   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_next = r_state;
      w_sos  = 1'b0;
      w_busy = 1'b1;
      case (r_state)
         S_FETCH:    w_next = S_WAIT_MEM;
         S_WAIT_MEM: if (w_ack) w_next = S_DECODE;
         S_DECODE: begin
            if (w_dec_valid)     w_next = S_LAUNCH;
            else if (w_dec_halt) w_next = S_HALT;
            else                 w_next = S_FAULT;
         end
         S_LAUNCH: begin
            w_sos  = 1'b1;
            w_next = S_EXEC;
         end
         S_EXEC: begin
            if (eos)             w_next = S_UPDATE;
            else if (w_cnt_last) w_next = S_FAULT;
         end
         S_UPDATE:   w_next = S_FETCH;
         S_HALT:     w_busy = 1'b0;
         S_FAULT:    w_busy = 1'b0;
         default:    w_next = S_FETCH;
      endcase
   end

   // Datapath registers: fetch handshake, IR, segment index, counter, flags, PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_ir       <= 32'd0;
         r_imem_req <= 1'b0;
         r_seg_idx  <= '1;
         r_halted   <= 1'b0;
         r_illegal  <= 1'b0;
         r_timeout  <= 1'b0;
         r_br       <= 1'b0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            S_FETCH: r_imem_req <= 1'b1;
            S_WAIT_MEM: begin
               if (w_ack) begin
                  r_ir       <= imem_rdata;
                  r_imem_req <= 1'b0;
               end
            end
            S_DECODE: begin
               r_seg_idx <= w_dec_seg;
               if (w_dec_halt)        r_halted  <= 1'b1;
               else if (!w_dec_valid) r_illegal <= 1'b1;
            end
            S_LAUNCH: r_cnt <= '0;
            S_EXEC: begin
               if (eos)             r_br      <= br_taken;
               else if (w_cnt_last) r_timeout <= 1'b1;
               else                 r_cnt     <= r_cnt + CNT_W'(1);
            end
            S_UPDATE: r_pc <= w_pc_next;
            default: ;
         endcase
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_pc;
   assign seg_idx   = r_seg_idx;
   assign sos       = w_sos;
   assign ir        = r_ir;
   assign pc        = r_pc;
   assign busy      = w_busy;
   assign halted    = r_halted;
   assign illegal   = r_illegal;
   assign timeout   = r_timeout;

endmodule
